// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle arithmetic/logic ops plus an iterative 1-bit-per-cycle
// variable shifter, with valid/ready handshakes on both sides and a pipeline flush.

`ifndef AND_OP
`define AND_OP  3'b000
`define OR_OP   3'b001
`define ADD_OP  3'b010
`define SLLV_OP 3'b011
`define SRLV_OP 3'b100
`define NO_OP   3'b101
`define SUB_OP  3'b110
`define SLT_OP  3'b111
`endif

module alu_exec_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                left_q, left_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                is_shift;
  logic                long_shift;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   op_res;
  logic [DATA_W-1:0]   shift_step;
  logic                last_step;

  assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign shamt      = src_a[SHAMT_W-1:0];
  assign is_shift   = (alu_control == `SLLV_OP) | (alu_control == `SRLV_OP);
  assign long_shift = is_shift & (shamt != SHAMT_W'(0));
  assign shift_step = left_q ? (shreg_q << 1) : (shreg_q >> 1);
  assign last_step  = (cnt_q == SHAMT_W'(1));

  // Single-cycle result; zero-amount shifts simply pass operand B through.
  always_comb begin
    op_res = '0;
    case (alu_control)
      `ADD_OP:  op_res = src_a + src_b;
      `SUB_OP:  op_res = src_a - src_b;
      `AND_OP:  op_res = src_a & src_b;
      `OR_OP:   op_res = src_a | src_b;
      `SLT_OP:  op_res = DATA_W'($signed(src_a) < $signed(src_b));
      `SLLV_OP: op_res = src_b;
      `SRLV_OP: op_res = src_b;
      default:  op_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (accept) begin
      state_d = long_shift ? S_SHIFT : S_DONE;
    end else begin
      case (state_q)
        S_SHIFT: if (last_step) state_d = S_DONE;
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values; result only ever updates with a finished value.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_SHIFT);
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      shreg_d = src_b;
      cnt_d   = shamt;
      left_d  = (alu_control == `SLLV_OP);
      if (!long_shift) begin
        result_d = op_res;
        zero_d   = (op_res == '0);
      end
    end else if (state_q == S_SHIFT) begin
      shreg_d = shift_step;
      cnt_d   = cnt_q - SHAMT_W'(1);
      if (last_step) begin
        result_d = shift_step;
        zero_d   = (shift_step == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results are queued on issue and
// popped when out_valid appears; latency, busy, hold, flush and reset are checked.

`ifndef AND_OP
`define AND_OP  3'b000
`define OR_OP   3'b001
`define ADD_OP  3'b010
`define SLLV_OP 3'b011
`define SRLV_OP 3'b100
`define NO_OP   3'b101
`define SUB_OP  3'b110
`define SLT_OP  3'b111
`endif

module tb_alu_exec_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              busy;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_exec_unit #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b);
    exp_t e;
    logic [SHAMT_W-1:0] sh;
    sh = a[SHAMT_W-1:0];
    case (op)
      `ADD_OP:  e.res = a + b;
      `SUB_OP:  e.res = a - b;
      `AND_OP:  e.res = a & b;
      `OR_OP:   e.res = a | b;
      `SLT_OP:  e.res = ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
      `SLLV_OP: e.res = b << sh;
      `SRLV_OP: e.res = b >> sh;
      default:  e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, 64'(result), 64'(e.res));
      chk({tag, "_zero"}, 64'(zero), 64'(e.z));
    end
  endtask

  // Issue one op from IDLE, measure latency and busy cycles, then retire it.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input int exp_lat,
                        input logic [DATA_W-1:0] exp_res);
    int lat;
    int busy_n;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b; out_ready = 1'b1;
    sb.push_back(model(op, a, b));
    tick();
    in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
    lat = 1; busy_n = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    chk({tag, "_const"}, 64'(result), 64'(exp_res));
    pop_cmp(tag);
    tick();
    chk({tag, "_retired"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = `NO_OP; src_a = '0; src_b = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    run_op("add_ovf", `ADD_OP, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000);
    run_op("sub_zero", `SUB_OP, 32'd5, 32'd5, 1, 32'd0);
    run_op("slt_neg", `SLT_OP, 32'hFFFF_FFFF, 32'd1, 1, 32'd1);
    run_op("slt_swap", `SLT_OP, 32'd1, 32'hFFFF_FFFF, 1, 32'd0);
    run_op("and", `AND_OP, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200);
    run_op("sllv4", `SLLV_OP, 32'd4, 32'd1, 5, 32'h10);
    run_op("srlv31", `SRLV_OP, 32'd31, 32'h8000_0000, 32, 32'd1);
    run_op("sllv0", `SLLV_OP, 32'hFFFF_FFE0, 32'h0000_DEAD, 1, 32'h0000_DEAD);
    run_op("sllv_hi", `SLLV_OP, 32'h0000_0025, 32'd3, 6, 32'h60);
    run_op("srlv_out", `SRLV_OP, 32'd8, 32'h0000_00FF, 9, 32'd0);
    run_op("no_op", `NO_OP, 32'd3, 32'd4, 1, 32'd0);

    // Stall in DONE, then a back-to-back accept with no bubble.
    out_ready = 1'b0; in_valid = 1'b1; alu_control = `ADD_OP; src_a = 32'd3; src_b = 32'd4;
    sb.push_back(model(`ADD_OP, 32'd3, 32'd4));
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(result), 64'd7);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    pop_cmp("hold");
    out_ready = 1'b1; in_valid = 1'b1; alu_control = `OR_OP;
    src_a = 32'h0000_00F0; src_b = 32'h0000_000F;
    sb.push_back(model(`OR_OP, 32'h0000_00F0, 32'h0000_000F));
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_result", 64'(result), 64'hFF);
    pop_cmp("b2b");
    tick();
    chk("b2b_retired", 64'(out_valid), 64'd0);

    // Flush in the middle of a long shift.
    in_valid = 1'b1; alu_control = `SLLV_OP; src_a = 32'd20; src_b = 32'd1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("flush_never_valid", 64'(seen), 64'd0);
    run_op("post_flush", `ADD_OP, 32'd10, 32'd20, 1, 32'd30);

    // Asynchronous reset in the middle of a long shift.
    in_valid = 1'b1; alu_control = `SLLV_OP; src_a = 32'd20; src_b = 32'd1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_zero", 64'(zero), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    chk("arst_stays_idle", 64'(seen), 64'd0);
    run_op("post_rst", `SRLV_OP, 32'd3, 32'h0000_0080, 4, 32'h10);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 3-bit alu_control code from the ALU decoder, plus two register operands.
- Produces a registered result and zero flag toward the branch and writeback logic.
- ADD/SUB/AND/OR/SLT/NO_OP complete in one cycle. SLLV/SRLV use an iterative 1-bit-per-cycle shifter to save area.
- Valid/ready handshakes on input and output; flush input for pipeline squash.

Parameters:
- DATA_W, 32, operand and result width.
- SHAMT_W, 5, width of the shift-amount field taken from src_a[SHAMT_W-1:0]; must equal log2(DATA_W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash; aborts any operation in flight.
- in_valid  input  1  operands and control valid.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_control  input  3  operation code, encoded per the shared define macros ADD_OP, SUB_OP, AND_OP, OR_OP, SLT_OP, SLLV_OP, SRLV_OP, NO_OP.
- src_a  input  DATA_W  operand A (rs).
- src_b  input  DATA_W  operand B (rt/imm).
- out_valid  output  1  result and zero valid.
- out_ready  input  1  consumer accepts result.
- result  output  DATA_W  registered result.
- zero  output  1  registered (result == 0).
- busy  output  1  high while in SHIFT state.

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, result=0, zero=0, busy=0, shift counter=0. Release is synchronous to clk.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and never depends on in_valid.
- Accept = in_valid & in_ready. Operands and alu_control are sampled only on accept.
- Single-cycle ops, accepted at edge N: result/zero registered at N, state=DONE, out_valid=1 from N.
- ADD: a+b mod 2^DATA_W, no overflow trap.
- SUB: a-b mod 2^DATA_W, no overflow trap.
- AND: a&b. OR: a|b.
- SLT: 1 if $signed(a) < $signed(b), else 0, zero-extended.
- NO_OP or any unlisted code: result=0, zero=1.
- SLLV: result = b << a[SHAMT_W-1:0]. SRLV: result = b >> a[SHAMT_W-1:0], logical, zero-fill.
  - On accept, load shift reg with b and counter with the shamt.
  - If shamt==0: go directly to DONE with result=b. Latency is the same as a single-cycle op.
  - Else go to SHIFT, busy=1. Each cycle shift 1 bit in the selected direction and decrement the counter.
  - When the counter reaches 0, go to DONE with out_valid=1. Total latency = 1 + shamt cycles, maximum 32 for shamt=31.
- DONE: result, zero and out_valid hold stable until out_ready.
  - out_ready & !in_valid: IDLE, out_valid=0.
  - out_ready & in_valid: back-to-back accept of the new op; the new result replaces the old with no bubble.
- out_valid never asserts in IDLE or SHIFT.
- flush: highest priority after reset. Next state=IDLE, out_valid=0, busy=0, counter cleared; any accept in the same cycle is discarded. result/zero keep their last value (don't-care while out_valid=0).
- Reset asserted mid-SHIFT: immediate return to reset values. No partial result is ever presented.
- Input operand changes during SHIFT are ignored; in_ready=0 in SHIFT.

Test Plan:
- ADD_OP, a=0x7FFFFFFF, b=1 -> out_valid next edge, result=0x80000000, zero=0. SUB_OP a=5,b=5 -> result=0, zero=1.
- SLT_OP a=0xFFFFFFFF(-1), b=1 -> result=1. Swap operands -> result=0.
- SLLV_OP a=4, b=0x1 -> busy high 4 cycles, out_valid 5 cycles after accept, result=0x10. SRLV_OP a=31, b=0x80000000 -> result=1, latency 32. Shamt 0 -> result=b, latency 1.
- Hold out_ready=0 for 3 cycles in DONE -> result/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 (OR_OP 0xF0|0x0F) -> next cycle result=0xFF, no bubble.
- flush mid-SHIFT (SLLV a=20) at cycle 5 -> IDLE next cycle, out_valid never asserts, in_ready=1. Repeat with rst_n pulsed low mid-SHIFT -> all outputs reset immediately.
- Unlisted/NO_OP code with a=3,b=4 -> result=0, zero=1, latency 1.
